phy_traffic_checker: RTL and testbench

// - Synthesizable, parametrised traffic generator and dual-DUT comparator for the multi-lane PHY.
// - Drives N lanes in three phases:
//   - PRELOAD: a fixed pattern.
//   - LOOPBACK: receiver output fed back until the PHY reports IDLE.
//   - BURST: LFSR data with LFSR-driven valids.
// - Every cycle, compares the behavioural and synthesized PHY outputs (lane data, valid, IDLE).
// - Keeps per-lane sticky error flags and a saturating mismatch count.

---
 rtl/phy_tc_pkg.sv | 19 +
 rtl/phy_lane_cmp.sv | 30 +++
 rtl/phy_traffic_checker.sv | 170 +++++++++++++++++
 tb/tb_phy_traffic_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/phy_tc_pkg.sv
// Shared types and LFSR helper for the PHY traffic checker.
package phy_tc_pkg;

    typedef enum logic [2:0] {
        IDLE_S,
        PRELOAD,
        LOOPBACK,
        BURST,
        DONE
    } tc_state_e;

    // x^32 + x^22 + x^2 + x + 1, Galois form
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/phy_lane_cmp.sv
// One-lane comparator: combinational mismatch flag plus a sticky error bit.
module phy_lane_cmp #(
    parameter int DATA_W = 8
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic              a_valid,
    input  logic              b_valid,
    output logic              mismatch,
    output logic              err
);

    assign mismatch = (a_data != b_data) || (a_valid != b_valid);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if (en && mismatch) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/phy_traffic_checker.sv
// Three-phase PHY stimulus generator with a per-cycle behavioural-vs-synthesized comparator.
module phy_traffic_checker
    import phy_tc_pkg::*;
#(
    parameter int          LANES     = 4,
    parameter int          DATA_W    = 8,
    parameter logic [7:0]  PRE_BASE  = 8'hFF,
    parameter int          BURST_LEN = 16,
    parameter int          LOOP_TO   = 256,
    parameter logic [31:0] SEED      = 32'h1,
    parameter int          CNT_W     = 16
) (
    input  logic                    clk_4f,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    skip_loop,
    input  logic [LANES*DATA_W-1:0] loop_data,
    input  logic [LANES-1:0]        loop_valid,
    input  logic                    idle_in,
    input  logic [LANES*DATA_W-1:0] a_data,
    input  logic [LANES*DATA_W-1:0] b_data,
    input  logic [LANES-1:0]        a_valid,
    input  logic [LANES-1:0]        b_valid,
    input  logic                    a_idle,
    input  logic                    b_idle,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic [LANES-1:0]        valid_out,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [LANES-1:0]        lane_err,
    output logic                    idle_err,
    output logic [CNT_W-1:0]        mismatch_cnt
);

    localparam int LOOP_W  = $clog2(LOOP_TO + 1);
    localparam int BURST_W = $clog2(BURST_LEN + 1);
    localparam logic [LOOP_W-1:0]  LOOP_LAST  = LOOP_W'(LOOP_TO - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);

    tc_state_e             state, state_nxt;
    logic                  skip_q;
    logic [31:0]           lfsr, lfsr_nxt;
    logic [LOOP_W-1:0]     loop_cnt, loop_cnt_nxt;
    logic [BURST_W-1:0]    burst_cnt, burst_cnt_nxt;
    logic [LANES*DATA_W-1:0] data_nxt;
    logic [LANES-1:0]      valid_nxt;
    logic                  busy_nxt, done_nxt;
    logic                  timeout_hit;

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state     <= IDLE_S;
            skip_q    <= 1'b0;
            lfsr      <= SEED;
            loop_cnt  <= '0;
            burst_cnt <= '0;
            data_out  <= '0;
            valid_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            loop_cnt  <= loop_cnt_nxt;
            burst_cnt <= burst_cnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            if (start) skip_q <= skip_loop;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        lfsr_nxt      = lfsr;
        loop_cnt_nxt  = loop_cnt;
        burst_cnt_nxt = burst_cnt;
        data_nxt      = '0;
        valid_nxt     = '0;
        timeout_hit   = 1'b0;
        busy_nxt      = (state == PRELOAD) || (state == LOOPBACK) || (state == BURST);
        done_nxt      = (state == DONE);

        unique case (state)
            IDLE_S: ;
            PRELOAD: begin
                for (int i = 0; i < LANES; i++)
                    data_nxt[i*DATA_W +: DATA_W] = DATA_W'(8'(PRE_BASE - 8'(i * 8'h11)));
                valid_nxt     = '1;
                loop_cnt_nxt  = '0;
                burst_cnt_nxt = '0;
                state_nxt     = skip_q ? BURST : LOOPBACK;
            end
            LOOPBACK: begin
                data_nxt  = loop_data;
                valid_nxt = loop_valid;
                // IDLE takes priority over a timeout landing on the same cycle
                if (idle_in) begin
                    state_nxt = BURST;
                end else if (loop_cnt == LOOP_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = BURST;
                end else begin
                    loop_cnt_nxt = loop_cnt + 1'b1;
                end
            end
            BURST: begin
                for (int i = 0; i < LANES; i++)
                    data_nxt[i*DATA_W +: DATA_W] = DATA_W'(lfsr >> i);
                valid_nxt = lfsr[31 -: LANES];
                lfsr_nxt  = lfsr_next(lfsr);
                if (burst_cnt == BURST_LAST) state_nxt = DONE;
                else                         burst_cnt_nxt = burst_cnt + 1'b1;
            end
            DONE: ;
            default: state_nxt = IDLE_S;
        endcase

        if (start) begin
            state_nxt = PRELOAD;
            lfsr_nxt  = SEED;
        end
    end

    // Comparator: lanes, IDLE, saturating count and sticky flags
    logic             cmp_en;
    logic [LANES-1:0] lane_mis;
    logic             idle_mis;
    logic             any_mis;

    assign cmp_en   = busy | done;
    assign idle_mis = a_idle ^ b_idle;
    assign any_mis  = (|lane_mis) | idle_mis;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        phy_lane_cmp #(.DATA_W(DATA_W)) u_cmp (
            .clk_4f   (clk_4f),
            .reset    (reset),
            .en       (cmp_en),
            .clr      (start),
            .a_data   (a_data[g*DATA_W +: DATA_W]),
            .b_data   (b_data[g*DATA_W +: DATA_W]),
            .a_valid  (a_valid[g]),
            .b_valid  (b_valid[g]),
            .mismatch (lane_mis[g]),
            .err      (lane_err[g])
        );
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            mismatch_cnt <= '0;
            idle_err     <= 1'b0;
            timeout      <= 1'b0;
        end else if (start) begin
            mismatch_cnt <= '0;
            idle_err     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            if (cmp_en && any_mis && (mismatch_cnt != {CNT_W{1'b1}}))
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            if (cmp_en && idle_mis) idle_err <= 1'b1;
            if (timeout_hit)        timeout  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_phy_traffic_checker.sv
// Directed, table-driven bench: default instance plus a short-timeout, 2-bit-counter instance.
module tb_phy_traffic_checker;

    logic        clk_4f;
    logic        reset;
    logic        start;
    logic        skip_loop;
    logic [31:0] loop_data;
    logic [3:0]  loop_valid;
    logic        idle_in;
    logic [31:0] a_data, b_data;
    logic [3:0]  a_valid, b_valid;
    logic        a_idle, b_idle;

    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic        busy, done, timeout, idle_err;
    logic [3:0]  lane_err;
    logic [15:0] mismatch_cnt;

    logic [31:0] t_data_out;
    logic [3:0]  t_valid_out;
    logic        t_busy, t_done, t_timeout, t_idle_err;
    logic [3:0]  t_lane_err;
    logic [1:0]  t_mismatch_cnt;

    int checks = 0;
    int errors = 0;

    phy_traffic_checker dut (
        .clk_4f(clk_4f), .reset(reset), .start(start), .skip_loop(skip_loop),
        .loop_data(loop_data), .loop_valid(loop_valid), .idle_in(idle_in),
        .a_data(a_data), .b_data(b_data), .a_valid(a_valid), .b_valid(b_valid),
        .a_idle(a_idle), .b_idle(b_idle),
        .data_out(data_out), .valid_out(valid_out), .busy(busy), .done(done),
        .timeout(timeout), .lane_err(lane_err), .idle_err(idle_err),
        .mismatch_cnt(mismatch_cnt)
    );

    phy_traffic_checker #(.LOOP_TO(8), .CNT_W(2)) dut_t (
        .clk_4f(clk_4f), .reset(reset), .start(start), .skip_loop(skip_loop),
        .loop_data(loop_data), .loop_valid(loop_valid), .idle_in(idle_in),
        .a_data(a_data), .b_data(b_data), .a_valid(a_valid), .b_valid(b_valid),
        .a_idle(a_idle), .b_idle(b_idle),
        .data_out(t_data_out), .valid_out(t_valid_out), .busy(t_busy), .done(t_done),
        .timeout(t_timeout), .lane_err(t_lane_err), .idle_err(t_idle_err),
        .mismatch_cnt(t_mismatch_cnt)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] ld;
        logic [3:0]  lv;
        logic        idle;
        logic [31:0] exp_data;
        logic [3:0]  exp_valid;
        logic        exp_busy;
        logic        exp_timeout;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic do_start(input logic skip);
        start     = 1'b1;
        skip_loop = skip;
        tick();
        start     = 1'b0;
        skip_loop = 1'b0;
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [31:0] burst_word(input logic [31:0] s);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) d[i*8 +: 8] = s[i +: 8];
        return d;
    endfunction

    logic [31:0] m;

    initial begin
        // PRELOAD, three LOOPBACK cycles ending on idle_in, then hand-computed BURST words
        vecs[0] = '{32'h1122_3344, 4'h5, 1'b0, 32'hCCDD_EEFF, 4'hF, 1'b1, 1'b0};
        vecs[1] = '{32'h1122_3344, 4'h5, 1'b0, 32'h1122_3344, 4'h5, 1'b1, 1'b0};
        vecs[2] = '{32'h5566_7788, 4'hA, 1'b0, 32'h5566_7788, 4'hA, 1'b1, 1'b0};
        vecs[3] = '{32'h99AA_BBCC, 4'h3, 1'b1, 32'h99AA_BBCC, 4'h3, 1'b1, 1'b0};
        vecs[4] = '{32'h0,         4'h0, 1'b0, 32'h0000_0001, 4'h0, 1'b1, 1'b0};
        vecs[5] = '{32'h0,         4'h0, 1'b0, 32'h0000_0103, 4'h8, 1'b1, 1'b0};
        vecs[6] = '{32'h0,         4'h0, 1'b0, 32'h0000_0102, 4'hC, 1'b1, 1'b0};

        reset = 1'b0; start = 1'b0; skip_loop = 1'b0;
        loop_data = '0; loop_valid = '0; idle_in = 1'b0;
        a_data = '0; b_data = '0; a_valid = '0; b_valid = '0; a_idle = 1'b0; b_idle = 1'b0;

        #50;
        check("reset_outputs", {data_out, valid_out, busy, done, timeout, lane_err, idle_err, mismatch_cnt}, '0);
        check("reset_outputs_t", {t_data_out, t_valid_out, t_busy, t_done, t_timeout,
                                  t_lane_err, t_idle_err, t_mismatch_cnt}, '0);
        #40;
        reset = 1'b1;

        // Preload, loopback and first burst words
        do_start(1'b0);
        for (int r = 0; r < 7; r++) begin
            loop_data  = vecs[r].ld;
            loop_valid = vecs[r].lv;
            idle_in    = vecs[r].idle;
            tick();
            check($sformatf("vec%0d_data", r),    data_out,  vecs[r].exp_data);
            check($sformatf("vec%0d_valid", r),   valid_out, vecs[r].exp_valid);
            check($sformatf("vec%0d_busy", r),    busy,      vecs[r].exp_busy);
            check($sformatf("vec%0d_timeout", r), timeout,   vecs[r].exp_timeout);
        end
        idle_in = 1'b0;

        // Rest of the 16-cycle burst against the bench LFSR model
        m = 32'h6018_0001;
        for (int k = 0; k < 13; k++) begin
            tick();
            check($sformatf("burst%0d_data", k + 3),  data_out,  burst_word(m));
            check($sformatf("burst%0d_valid", k + 3), valid_out, m[31:28]);
            m = model_step(m);
        end
        tick();
        check("done_flag", {done, busy}, 2'b10);
        check("done_outputs", {data_out, valid_out}, '0);

        // skip_loop: PRELOAD straight into BURST, done after 16 burst cycles
        do_start(1'b1);
        tick();
        check("skip_preload", {data_out, valid_out}, {32'hCCDD_EEFF, 4'hF});
        tick();
        check("skip_burst0", {data_out, valid_out}, {32'h0000_0001, 4'h0});
        for (int k = 0; k < 15; k++) tick();
        check("skip_last_burst_done", done, 1'b0);
        tick();
        check("skip_done", {done, busy, data_out, valid_out}, {2'b10, 36'h0});

        // Timeout on the LOOP_TO=8 instance
        loop_data = 32'hDEAD_BEEF; loop_valid = 4'hF; idle_in = 1'b0;
        do_start(1'b0);
        for (int k = 0; k < 8; k++) tick();
        check("to_before", t_timeout, 1'b0);
        tick();
        check("to_set", {t_timeout, t_data_out}, {1'b1, 32'hDEAD_BEEF});
        tick();
        check("to_burst", {t_busy, t_data_out}, {1'b1, 32'h0000_0001});
        check("to_long_loop", {timeout, data_out}, {1'b0, 32'hDEAD_BEEF});

        // idle_in on the final allowed LOOPBACK cycle: no timeout
        do_start(1'b0);
        check("to_cleared", t_timeout, 1'b0);
        for (int k = 0; k < 8; k++) tick();
        idle_in = 1'b1;
        tick();
        idle_in = 1'b0;
        check("idle_wins", t_timeout, 1'b0);
        tick();
        check("idle_wins_burst", t_data_out, 32'h0000_0001);

        // Comparator
        a_data = 32'hA5A5_A5A5; b_data = 32'hA5A5_A5A5; a_valid = 4'hF; b_valid = 4'hF;
        do_start(1'b1);
        tick();
        check("cmp_clean", {lane_err, idle_err, mismatch_cnt}, '0);
        b_data = 32'hA5A5_A5A5 ^ 32'h0001_0000;
        for (int k = 0; k < 3; k++) tick();
        b_data = 32'hA5A5_A5A5;
        check("cmp_lane2", {lane_err, idle_err, mismatch_cnt}, {4'b0100, 1'b0, 16'd3});
        b_idle = 1'b1;
        tick();
        b_idle = 1'b0;
        check("cmp_idle", {lane_err, idle_err, mismatch_cnt}, {4'b0100, 1'b1, 16'd4});
        check("cmp_sat_t", t_mismatch_cnt, 2'd3);
        b_valid = 4'hF ^ 4'h2;
        tick();
        b_valid = 4'hF;
        check("cmp_valid1", {lane_err, mismatch_cnt}, {4'b0110, 16'd5});
        check("cmp_sat_hold_t", t_mismatch_cnt, 2'd3);
        tick();
        check("cmp_quiet", mismatch_cnt, 16'd5);

        // Mid-burst restart, then async reset mid-loopback
        loop_data = 32'h1122_3344; loop_valid = 4'h5; idle_in = 1'b0;
        do_start(1'b0);
        check("restart_clear", {lane_err, idle_err, timeout, mismatch_cnt}, '0);
        tick();
        check("restart_preload", {data_out, valid_out}, {32'hCCDD_EEFF, 4'hF});
        tick();
        tick();
        check("restart_loop", {data_out, valid_out}, {32'h1122_3344, 4'h5});
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {data_out, valid_out, busy, done, timeout, lane_err, idle_err, mismatch_cnt}, '0);
        #2;
        reset = 1'b1;
        tick();
        check("post_reset_idle", {data_out, valid_out, busy, done}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
